snow64_mem_bus_arbiter: RTL and testbench

Sequential arbiter sharing the single memory bus guard port between the instruction cache's line-fill path and the LAR file's line load/store path. It accepts one transaction at a time, holds the bus request stable until the bus completes it, and returns the response to the winning requester. Grants alternate round-robin by default. It sits between the memory accessor requesters and the memory bus guard, inside the CPU top level.

---
 rtl/snow64_mem_bus_arbiter_pkg.sv | 37 +++
 rtl/snow64_mem_bus_arbiter_pick.sv | 28 ++
 rtl/snow64_mem_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_snow64_mem_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snow64_mem_bus_arbiter_pkg.sv
// Shared widths, state/requester enums and bundle structs for the memory bus arbiter.
// Imported by snow64_mem_bus_arbiter and snow64_mem_bus_arbiter_pick.
package PkgSnow64MemBusArbiter;

  localparam int ADDR_WIDTH = 64;
  localparam int LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY_INSTR = 2'd1,
    BUSY_DATA  = 2'd2
  } state_e;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic                  valid;
    logic [LINE_WIDTH-1:0] data;
  } resp_t;

  typedef struct packed {
    logic                  req;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] wdata;
  } mem_port_t;

endpackage

// File: rtl/snow64_mem_bus_arbiter_pick.sv
// Combinational winner select between the instruction and data requesters.
// SNOW64_MEM_BUS_ARBITER_FIXED_PRIORITY_EN: data wins every tie and no last_grant input exists.
module snow64_mem_bus_arbiter_pick
  import PkgSnow64MemBusArbiter::*;
(
  input  logic    i_instr_valid,
  input  logic    i_data_valid,
`ifndef SNOW64_MEM_BUS_ARBITER_FIXED_PRIORITY_EN
  input  req_id_e i_last_grant,
`endif
  output req_id_e o_winner
);

  always_comb begin
    // NOTE: default assigned first so every path drives o_winner and no latch is inferred.
    o_winner = INSTR;
    if (i_data_valid && !i_instr_valid) begin
      o_winner = DATA;
    end else if (i_data_valid && i_instr_valid) begin
`ifdef SNOW64_MEM_BUS_ARBITER_FIXED_PRIORITY_EN
      o_winner = DATA;
`else
      o_winner = (i_last_grant == INSTR) ? DATA : INSTR;
`endif
    end
  end

endmodule

// File: rtl/snow64_mem_bus_arbiter.sv
// Shares the memory bus guard port between instruction line fills and LAR line loads/stores.
// SNOW64_MEM_BUS_ARBITER_FIXED_PRIORITY_EN selects fixed data priority instead of round-robin.
module snow64_mem_bus_arbiter #(
  parameter int ADDR_WIDTH = PkgSnow64MemBusArbiter::ADDR_WIDTH,
  parameter int LINE_WIDTH = PkgSnow64MemBusArbiter::LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_instr_req_valid,
  input  logic [ADDR_WIDTH-1:0] in_instr_req_addr,
  output logic                  out_instr_req_ack,
  output logic                  out_instr_resp_valid,
  output logic [LINE_WIDTH-1:0] out_instr_resp_data,
  input  logic                  in_data_req_valid,
  input  logic                  in_data_req_write,
  input  logic [ADDR_WIDTH-1:0] in_data_req_addr,
  input  logic [LINE_WIDTH-1:0] in_data_req_wdata,
  output logic                  out_data_req_ack,
  output logic                  out_data_resp_valid,
  output logic [LINE_WIDTH-1:0] out_data_resp_data,
  output logic                  out_mem_req,
  output logic                  out_mem_write,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  output logic [LINE_WIDTH-1:0] out_mem_wdata,
  input  logic                  in_mem_done,
  input  logic [LINE_WIDTH-1:0] in_mem_rdata
);

  import PkgSnow64MemBusArbiter::*;

  state_e    r_state;
  mem_port_t r_mem;
  resp_t     r_instr_resp;
  resp_t     r_data_resp;
  logic      r_instr_ack;
  logic      r_data_ack;
`ifndef SNOW64_MEM_BUS_ARBITER_FIXED_PRIORITY_EN
  req_id_e   r_last_grant;
`endif

  req_t      w_instr_req;
  req_t      w_data_req;
  req_t      w_win_req;
  req_id_e   w_winner;
  logic      w_any_valid;

  // The fetch side is read-only, so its bundle carries no write or store data.
  assign w_instr_req = '{write: 1'b0, addr: in_instr_req_addr, wdata: '0};
  assign w_data_req  = '{write: in_data_req_write, addr: in_data_req_addr,
                         wdata: in_data_req_wdata};
  assign w_any_valid = in_instr_req_valid | in_data_req_valid;
  assign w_win_req   = (w_winner == DATA) ? w_data_req : w_instr_req;

  snow64_mem_bus_arbiter_pick u_pick (
    .i_instr_valid (in_instr_req_valid),
    .i_data_valid  (in_data_req_valid),
`ifndef SNOW64_MEM_BUS_ARBITER_FIXED_PRIORITY_EN
    .i_last_grant  (r_last_grant),
`endif
    .o_winner      (w_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mem        <= '0;
      r_instr_resp <= '0;
      r_data_resp  <= '0;
      r_instr_ack  <= 1'b0;
      r_data_ack   <= 1'b0;
`ifndef SNOW64_MEM_BUS_ARBITER_FIXED_PRIORITY_EN
      r_last_grant <= DATA;
`endif
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      r_instr_ack        <= 1'b0;
      r_data_ack         <= 1'b0;
      r_instr_resp.valid <= 1'b0;
      r_data_resp.valid  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_mem <= '{req: 1'b1, write: w_win_req.write, addr: w_win_req.addr,
                       wdata: w_win_req.wdata};
            if (w_winner == DATA) begin
              r_data_ack <= 1'b1;
              r_state    <= BUSY_DATA;
            end else begin
              r_instr_ack <= 1'b1;
              r_state     <= BUSY_INSTR;
            end
`ifndef SNOW64_MEM_BUS_ARBITER_FIXED_PRIORITY_EN
            r_last_grant <= w_winner;
`endif
          end
        end
        BUSY_INSTR: begin
          if (in_mem_done) begin
            r_instr_resp <= '{valid: 1'b1, data: in_mem_rdata};
            r_mem        <= '0;
            r_state      <= IDLE;
          end
        end
        BUSY_DATA: begin
          if (in_mem_done) begin
            r_data_resp <= '{valid: 1'b1,
                             data: r_mem.write ? {LINE_WIDTH{1'b0}} : in_mem_rdata};
            r_mem       <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_instr_req_ack    = r_instr_ack;
  assign out_instr_resp_valid = r_instr_resp.valid;
  assign out_instr_resp_data  = r_instr_resp.data;
  assign out_data_req_ack     = r_data_ack;
  assign out_data_resp_valid  = r_data_resp.valid;
  assign out_data_resp_data   = r_data_resp.data;
  assign out_mem_req          = r_mem.req;
  assign out_mem_write        = r_mem.write;
  assign out_mem_addr         = r_mem.addr;
  assign out_mem_wdata        = r_mem.wdata;

endmodule

// File: tb/tb_snow64_mem_bus_arbiter.sv
// Directed self-checking bench for snow64_mem_bus_arbiter (round-robin or fixed priority
// depending on SNOW64_MEM_BUS_ARBITER_FIXED_PRIORITY_EN).
module tb_snow64_mem_bus_arbiter;

  localparam int AW = 64;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_instr_req_valid;
  logic [AW-1:0] in_instr_req_addr;
  logic          out_instr_req_ack;
  logic          out_instr_resp_valid;
  logic [LW-1:0] out_instr_resp_data;
  logic          in_data_req_valid;
  logic          in_data_req_write;
  logic [AW-1:0] in_data_req_addr;
  logic [LW-1:0] in_data_req_wdata;
  logic          out_data_req_ack;
  logic          out_data_resp_valid;
  logic [LW-1:0] out_data_resp_data;
  logic          out_mem_req;
  logic          out_mem_write;
  logic [AW-1:0] out_mem_addr;
  logic [LW-1:0] out_mem_wdata;
  logic          in_mem_done;
  logic [LW-1:0] in_mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  snow64_mem_bus_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_instr_req_valid   (in_instr_req_valid),
    .in_instr_req_addr    (in_instr_req_addr),
    .out_instr_req_ack    (out_instr_req_ack),
    .out_instr_resp_valid (out_instr_resp_valid),
    .out_instr_resp_data  (out_instr_resp_data),
    .in_data_req_valid    (in_data_req_valid),
    .in_data_req_write    (in_data_req_write),
    .in_data_req_addr     (in_data_req_addr),
    .in_data_req_wdata    (in_data_req_wdata),
    .out_data_req_ack     (out_data_req_ack),
    .out_data_resp_valid  (out_data_resp_valid),
    .out_data_resp_data   (out_data_resp_data),
    .out_mem_req          (out_mem_req),
    .out_mem_write        (out_mem_write),
    .out_mem_addr         (out_mem_addr),
    .out_mem_wdata        (out_mem_wdata),
    .in_mem_done          (in_mem_done),
    .in_mem_rdata         (in_mem_rdata)
  );

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " instr_ack"},   LW'(out_instr_req_ack),    '0);
    check({tag, " data_ack"},    LW'(out_data_req_ack),     '0);
    check({tag, " instr_rv"},    LW'(out_instr_resp_valid), '0);
    check({tag, " data_rv"},     LW'(out_data_resp_valid),  '0);
    check({tag, " instr_rdata"}, out_instr_resp_data,       '0);
    check({tag, " data_rdata"},  out_data_resp_data,        '0);
    check({tag, " mem_req"},     LW'(out_mem_req),          '0);
    check({tag, " mem_write"},   LW'(out_mem_write),        '0);
    check({tag, " mem_addr"},    LW'(out_mem_addr),         '0);
    check({tag, " mem_wdata"},   out_mem_wdata,             '0);
  endtask

  initial begin
    logic          fixed_prio;
    logic          exp_instr;
    logic [LW-1:0] pat;

`ifdef SNOW64_MEM_BUS_ARBITER_FIXED_PRIORITY_EN
    fixed_prio = 1'b1;
`else
    fixed_prio = 1'b0;
`endif

    rst                = 1'b1;
    in_instr_req_valid = 1'b0;
    in_instr_req_addr  = '0;
    in_data_req_valid  = 1'b0;
    in_data_req_write  = 1'b0;
    in_data_req_addr   = '0;
    in_data_req_wdata  = '0;
    in_mem_done        = 1'b0;
    in_mem_rdata       = '0;

    // Reset state.
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Lone fetch from 0x1000.
    in_instr_req_valid = 1'b1;
    in_instr_req_addr  = 64'h1000;
    tick();
    check("fetch ack",       LW'(out_instr_req_ack), LW'(1));
    check("fetch data_ack",  LW'(out_data_req_ack),  LW'(0));
    check("fetch mem_req",   LW'(out_mem_req),       LW'(1));
    check("fetch mem_write", LW'(out_mem_write),     LW'(0));
    check("fetch mem_addr",  LW'(out_mem_addr),      LW'(64'h1000));
    in_instr_req_valid = 1'b0;
    tick();
    check("fetch ack pulse", LW'(out_instr_req_ack), LW'(0));
    check("fetch req held",  LW'(out_mem_req),       LW'(1));
    in_mem_done  = 1'b1;
    in_mem_rdata = {32{8'hAA}};
    tick();
    in_mem_done  = 1'b0;
    in_mem_rdata = '0;
    check("fetch resp_valid", LW'(out_instr_resp_valid), LW'(1));
    check("fetch resp_data",  out_instr_resp_data,       {32{8'hAA}});
    check("fetch data_rv",    LW'(out_data_resp_valid),  LW'(0));
    check("fetch req drop",   LW'(out_mem_req),          LW'(0));
    tick();
    check("fetch rv pulse",   LW'(out_instr_resp_valid), LW'(0));
    check("fetch data hold",  out_instr_resp_data,       {32{8'hAA}});

    // Lone store to 0x2000; completion arrives the first cycle out_mem_req is high.
    in_data_req_valid = 1'b1;
    in_data_req_write = 1'b1;
    in_data_req_addr  = 64'h2000;
    in_data_req_wdata = {32{8'h55}};
    tick();
    check("store ack",       LW'(out_data_req_ack),  LW'(1));
    check("store instr_ack", LW'(out_instr_req_ack), LW'(0));
    check("store mem_req",   LW'(out_mem_req),       LW'(1));
    check("store mem_write", LW'(out_mem_write),     LW'(1));
    check("store mem_addr",  LW'(out_mem_addr),      LW'(64'h2000));
    check("store mem_wdata", out_mem_wdata,          {32{8'h55}});
    in_data_req_valid = 1'b0;
    in_data_req_write = 1'b0;
    in_data_req_wdata = '0;
    in_mem_done       = 1'b1;
    in_mem_rdata      = {8{32'h1234_5678}};
    tick();
    in_mem_done  = 1'b0;
    in_mem_rdata = '0;
    check("store resp_valid", LW'(out_data_resp_valid),  LW'(1));
    check("store resp_data",  out_data_resp_data,        '0);
    check("store instr_rv",   LW'(out_instr_resp_valid), LW'(0));
    check("store instr hold", out_instr_resp_data,       {32{8'hAA}});

    // Fresh reset, then both requesters hold valid high for four transactions.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_instr_req_valid = 1'b1;
    in_instr_req_addr  = 64'h3000;
    in_data_req_valid  = 1'b1;
    in_data_req_write  = 1'b0;
    in_data_req_addr   = 64'h4000;
    for (int i = 0; i < 4; i++) begin
      exp_instr = fixed_prio ? 1'b0 : ((i % 2) == 0);
      pat       = {8{32'hC0DE_0000 + 32'(i)}};
      tick();
      check($sformatf("rr%0d instr_ack", i), LW'(out_instr_req_ack), LW'(exp_instr));
      check($sformatf("rr%0d data_ack", i),  LW'(out_data_req_ack),  LW'(!exp_instr));
      check($sformatf("rr%0d mem_req", i),   LW'(out_mem_req),       LW'(1));
      check($sformatf("rr%0d mem_addr", i),  LW'(out_mem_addr),
            LW'(exp_instr ? 64'h3000 : 64'h4000));
      in_mem_done  = 1'b1;
      in_mem_rdata = pat;
      tick();
      in_mem_done  = 1'b0;
      in_mem_rdata = '0;
      check($sformatf("rr%0d instr_rv", i), LW'(out_instr_resp_valid), LW'(exp_instr));
      check($sformatf("rr%0d data_rv", i),  LW'(out_data_resp_valid),  LW'(!exp_instr));
      check($sformatf("rr%0d idle gap", i), LW'(out_mem_req),          LW'(0));
      if (exp_instr) check($sformatf("rr%0d instr_data", i), out_instr_resp_data, pat);
      else           check($sformatf("rr%0d data_data", i),  out_data_resp_data,  pat);
    end
    in_instr_req_valid = 1'b0;
    in_data_req_valid  = 1'b0;
    tick();
    check("rr end idle", LW'(out_mem_req), LW'(0));

    // Reset while a store is on the bus, then a late completion.
    in_data_req_valid = 1'b1;
    in_data_req_write = 1'b1;
    in_data_req_addr  = 64'h5000;
    in_data_req_wdata = {32{8'h77}};
    tick();
    check("abort busy", LW'(out_mem_req), LW'(1));
    in_data_req_valid = 1'b0;
    in_data_req_write = 1'b0;
    in_data_req_wdata = '0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("abort async");
    tick();
    rst          = 1'b0;
    in_mem_done  = 1'b1;
    in_mem_rdata = {32{8'h99}};
    tick();
    in_mem_done  = 1'b0;
    in_mem_rdata = '0;
    check_all_zero("abort late done");

    // Spurious completion while idle, then a fetch proves the arbiter is still idle.
    in_mem_done  = 1'b1;
    in_mem_rdata = {32{8'hFF}};
    tick();
    in_mem_done  = 1'b0;
    in_mem_rdata = '0;
    check_all_zero("spurious");
    in_instr_req_valid = 1'b1;
    in_instr_req_addr  = 64'h6000;
    tick();
    check("post spur ack",  LW'(out_instr_req_ack), LW'(1));
    check("post spur addr", LW'(out_mem_addr),      LW'(64'h6000));
    in_instr_req_valid = 1'b0;
    in_mem_done        = 1'b1;
    in_mem_rdata       = {16{16'hBEEF}};
    tick();
    in_mem_done  = 1'b0;
    in_mem_rdata = '0;
    check("post spur rv",   LW'(out_instr_resp_valid), LW'(1));
    check("post spur data", out_instr_resp_data,       {16{16'hBEEF}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
